sensor_trace_packer: RTL and testbench

//  Sits between the delay-line sensor output (sensor_clk domain) and the write side of sensor_fifo.
//  On a capture trigger it reduces each 128-bit thermometer-coded sensor sample to its Hamming weight.
//  It packs 16 weights per 128-bit FIFO word, cutting trace storage and readout traffic 16x.

---
 rtl/sensor_trace_pkg.sv | 21 ++
 rtl/popcount_tree.sv | 28 ++
 rtl/sensor_trace_packer.sv | 164 ++++++++++++++++
 tb/tb_sensor_trace_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_trace_pkg.sv
// Shared types and constants for the sensor trace packer.
// Build option: TRACE_RAW_BYPASS_EN enables the raw-sample bypass.
package sensor_trace_pkg;

   localparam int SENSOR_WIDTH = 128;
   localparam int HW_WIDTH     = 8;
   localparam int PACK         = SENSOR_WIDTH / HW_WIDTH;
   localparam int TREE_LVLS    = $clog2(SENSOR_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } state_t;

   // Partial sums at tree level l cover 2**l bits, so they need l+1 bits.
   function automatic int pc_width(input int lvl);
      return lvl + 1;
   endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational 128-to-8 Hamming weight as a pairwise adder tree.
// No registers, so retiming the tree stays inside this module.
module popcount_tree
   import sensor_trace_pkg::*;
(
   input  logic [SENSOR_WIDTH-1:0] bits,
   output logic [HW_WIDTH-1:0]     weight
);

   for (genvar l = 1; l <= TREE_LVLS; l++) begin : g_lvl
      localparam int N = SENSOR_WIDTH >> l;
      localparam int W = pc_width(l);
      logic [N*W-1:0] sum;
      for (genvar i = 0; i < N; i++) begin : g_add
         if (l == 1) begin : g_leaf
            assign sum[i*W +: W] = {1'b0, bits[2*i]}
                                 + {1'b0, bits[2*i+1]};
         end else begin : g_node
            assign sum[i*W +: W] =
               {1'b0, g_lvl[l-1].sum[2*i*(W-1) +: W-1]}
             + {1'b0, g_lvl[l-1].sum[(2*i+1)*(W-1) +: W-1]};
         end
      end
   end

   assign weight = g_lvl[TREE_LVLS].sum;

endmodule

// File: rtl/sensor_trace_packer.sv
// Captures delay-line samples, reduces them to weights, packs 16 per word.
// Build option: TRACE_RAW_BYPASS_EN adds raw_mode_i for unpacked samples.
module sensor_trace_packer
   import sensor_trace_pkg::*;
#(
   parameter int N_SAMPLES = 2048
) (
   input  logic                    clk_in,
   input  logic                    reset_n,
   input  logic [SENSOR_WIDTH-1:0] sensor_i,
   input  logic                    trigger_i,
   input  logic                    fifo_full_i,
`ifdef TRACE_RAW_BYPASS_EN
   input  logic                    raw_mode_i,
`endif
   output logic [SENSOR_WIDTH-1:0] sensor_o,
   output logic                    sensor_dvld_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    overflow_o
);

   localparam int CW = $clog2(N_SAMPLES + 1);
   localparam int PW = $clog2(PACK);
   localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
   localparam logic [CW-1:0] FULL = CW'(N_SAMPLES);

   state_t                  state;
   state_t                  nxt;
   logic [CW-1:0]           cnt;
   logic [1:0]              dcnt;
   logic                    accept;
   logic                    take;
   logic                    fin;
   logic                    busy;
   logic [SENSOR_WIDTH-1:0] s_q;
   logic [SENSOR_WIDTH-1:0] pack;
   logic [SENSOR_WIDTH-1:0] word_d;
   logic [SENSOR_WIDTH-1:0] out_q;
   logic                    s_vld;
   logic                    hw_vld;
   logic                    word_q;
   logic                    emit;
   logic                    ovf_q;
   logic                    done_q;
   logic [HW_WIDTH-1:0]     hw;
   logic [HW_WIDTH-1:0]     hw_q;
   logic [PW-1:0]           wcnt;

   popcount_tree u_pc (
      .bits   (s_q),
      .weight (hw)
   );

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (trigger_i) nxt = CAPTURE;
         CAPTURE: if (cnt == LAST) nxt = DRAIN;
         DRAIN:   if (dcnt == 2'd2) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      take   = 1'b0;
      fin    = 1'b0;
      busy   = 1'b0;
      unique case (state)
         IDLE:    accept = trigger_i;
         CAPTURE: begin
            take = 1'b1;
            busy = 1'b1;
         end
         DRAIN:   begin
            busy = 1'b1;
            fin  = (dcnt == 2'd2);
         end
         default: ;
      endcase
   end

`ifdef TRACE_RAW_BYPASS_EN
   logic                    raw_q;
   logic [SENSOR_WIDTH-1:0] dly_q;

   // Raw path mirrors the hw_q stage so both modes share the same latency.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         raw_q <= 1'b0;
         dly_q <= '0;
      end else begin
         if (accept) raw_q <= raw_mode_i;
         dly_q <= s_q;
      end
   end
`endif

   always_comb begin
      word_d = {hw_q, pack[SENSOR_WIDTH-1:HW_WIDTH]};
      emit   = hw_vld && (wcnt == PW'(PACK - 1));
`ifdef TRACE_RAW_BYPASS_EN
      if (raw_q) begin
         word_d = dly_q;
         emit   = hw_vld;
      end
`endif
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         dcnt   <= '0;
         s_q    <= '0;
         s_vld  <= 1'b0;
         hw_q   <= '0;
         hw_vld <= 1'b0;
         pack   <= '0;
         wcnt   <= '0;
         out_q  <= '0;
         word_q <= 1'b0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         if (accept)
            cnt <= '0;
         else if (take && cnt != FULL)
            cnt <= cnt + CW'(1);
         dcnt <= (state == DRAIN && !fin) ? dcnt + 2'd1 : 2'd0;
         if (take) s_q <= sensor_i;
         s_vld  <= take;
         hw_q   <= hw;
         hw_vld <= s_vld;
         if (accept) begin
            pack <= '0;
            wcnt <= '0;
         end else if (hw_vld) begin
            pack <= {hw_q, pack[SENSOR_WIDTH-1:HW_WIDTH]};
            wcnt <= wcnt + PW'(1);
         end
         if (emit) out_q <= word_d;
         word_q <= emit;
         // The sensor cannot stall: a full FIFO loses the word.
         if (accept)
            ovf_q <= 1'b0;
         else if (word_q && fifo_full_i)
            ovf_q <= 1'b1;
         done_q <= fin;
      end
   end

   assign sensor_o      = out_q;
   assign sensor_dvld_o = word_q & ~fifo_full_i;
   assign busy_o        = busy;
   assign done_o        = done_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_sensor_trace_packer.sv
// Directed/random bench for sensor_trace_packer with N_SAMPLES=32.
// Build option: TRACE_RAW_BYPASS_EN also exercises raw mode.
module tb_sensor_trace_packer;

   localparam int N  = 32;
   localparam int PK = 16;

   logic         clk_in      = 1'b0;
   logic         reset_n     = 1'b0;
   logic [127:0] sensor_i    = '0;
   logic         trigger_i   = 1'b0;
   logic         fifo_full_i = 1'b0;
`ifdef TRACE_RAW_BYPASS_EN
   logic         raw_mode_i  = 1'b0;
`endif
   logic [127:0] sensor_o;
   logic         sensor_dvld_o;
   logic         busy_o;
   logic         done_o;
   logic         overflow_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int full_cyc = -1;
   int done_cnt = 0;
   int done_at  = 0;
   logic busy_at_done  = 1'b0;
   logic busy_pre_done = 1'b0;
   logic prev_busy     = 1'b0;

   logic [127:0] smp[$];
   logic [127:0] obs_w[$];
   int           obs_c[$];

   sensor_trace_packer #(.N_SAMPLES(N)) dut (
      .clk_in        (clk_in),
      .reset_n       (reset_n),
      .sensor_i      (sensor_i),
      .trigger_i     (trigger_i),
      .fifo_full_i   (fifo_full_i),
`ifdef TRACE_RAW_BYPASS_EN
      .raw_mode_i    (raw_mode_i),
`endif
      .sensor_o      (sensor_o),
      .sensor_dvld_o (sensor_dvld_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .overflow_o    (overflow_o)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (sensor_dvld_o) begin
         obs_w.push_back(sensor_o);
         obs_c.push_back(cyc);
      end
      if (done_o) begin
         done_cnt++;
         done_at       = cyc;
         busy_at_done  = busy_o;
         busy_pre_done = prev_busy;
      end
      prev_busy = busy_o;
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      fifo_full_i = (cyc == full_cyc);
   endtask

   function automatic logic [127:0] therm(input int n);
      logic [127:0] one;
      one = 128'd1;
      return (one << n) - one;
   endfunction

   // 0 all ones, 1 ramp of j%16 ones, 2 random mix, 4 cycle count, else 0
   function automatic logic [127:0] gen(input int pat, input int j);
      case (pat)
         0: return '1;
         1: return therm(j % PK);
         2: begin
            if (j % 2 == 0) return therm(int'($urandom_range(0, 128)));
            return {$urandom, $urandom, $urandom, $urandom};
         end
         4: return 128'(cyc);
         default: return '0;
      endcase
   endfunction

   function automatic logic [127:0] model_word(input int w, input bit raw);
      logic [127:0] r;
      r = '0;
      if (raw) return smp[w];
      for (int k = 0; k < PK; k++)
         r[8*k +: 8] = 8'($countones(smp[PK*w+k]));
      return r;
   endfunction

   task automatic run(input string tag, input int pat, input int drop,
                      input bit raw);
      int ca;
      int per;
      int nw;
      int k;
      smp.delete();
      obs_w.delete();
      obs_c.delete();
      done_cnt = 0;
      per = raw ? 1 : PK;
      nw  = N / per;
      trigger_i = 1'b1;
`ifdef TRACE_RAW_BYPASS_EN
      raw_mode_i = raw;
`endif
      tick();
      ca = cyc;
      trigger_i = 1'b0;
      full_cyc = (drop >= 0) ? ca + per*drop + per + 2 : -1;
      chk({tag, "_busy_on"}, 128'(busy_o), 128'(1));
      chk({tag, "_ovf_clr"}, 128'(overflow_o), 128'(0));
      for (int j = 0; j < N; j++) begin
         sensor_i = gen(pat, j);
         smp.push_back(sensor_i);
         tick();
      end
      sensor_i = '0;
      for (int t = 0; t < 20 && done_cnt == 0; t++) tick();
      repeat (4) tick();
      chk({tag, "_done_once"}, 128'(done_cnt), 128'(1));
      k = 0;
      for (int w = 0; w < nw; w++) begin
         if (w != drop) begin
            if (k < obs_w.size()) begin
               chk($sformatf("%s_word%0d", tag, w), obs_w[k],
                   model_word(w, raw));
               chk($sformatf("%s_cyc%0d", tag, w), 128'(obs_c[k]),
                   128'(ca + per*w + per + 2));
            end
            k++;
         end
      end
      chk({tag, "_nstrobe"}, 128'(obs_w.size()), 128'(k));
      if (done_cnt > 0 && obs_c.size() > 0)
         chk({tag, "_done_after"}, 128'(done_at > obs_c[$]), 128'(1));
      chk({tag, "_busy_fall"}, 128'(busy_at_done), 128'(0));
      chk({tag, "_busy_pre"}, 128'(busy_pre_done), 128'(1));
      chk({tag, "_ovf"}, 128'(overflow_o), 128'(drop >= 0));
      chk({tag, "_hold"}, sensor_o, model_word(nw - 1, raw));
      chk({tag, "_idle"}, 128'(busy_o), 128'(0));
      full_cyc = -1;
   endtask

   initial begin
      // reset state, then idle with no trigger
      repeat (3) tick();
      chk("rst_data", sensor_o, '0);
      chk("rst_ctrl", 128'({sensor_dvld_o, busy_o, done_o, overflow_o}),
          128'(0));
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("idle_busy%0d", i), 128'(busy_o), 128'(0));
      end
      chk("idle_nostrobe", 128'(obs_w.size()), 128'(0));

      run("ones", 0, -1, 1'b0);
      if (obs_w.size() > 0)
         chk("ones_const", obs_w[0], {16{8'h80}});

      run("ramp", 1, -1, 1'b0);
      if (obs_w.size() > 0)
         chk("ramp_const", obs_w[0],
             128'h0F0E0D0C0B0A09080706050403020100);

      run("ovf", 2, 0, 1'b0);
      run("retrig", 2, -1, 1'b0);

      // reset in the middle of a capture
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      for (int j = 0; j < 5; j++) begin
         sensor_i = '1;
         tick();
      end
      reset_n = 1'b0;
      #1;
      chk("midrst_data", sensor_o, '0);
      chk("midrst_ctrl", 128'({sensor_dvld_o, busy_o, done_o, overflow_o}),
          128'(0));
      tick();
      reset_n = 1'b1;
      sensor_i = '0;
      tick();
      chk("midrst_idle", 128'(busy_o), 128'(0));
      run("zero", 3, -1, 1'b0);

`ifdef TRACE_RAW_BYPASS_EN
      run("raw", 4, -1, 1'b1);
      raw_mode_i = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
